// File: rtl/sub_bytes_seq_if.sv
// Valid/ready bundle between the round controller, the SubBytes engine and ShiftRows.
// slave is the engine's view; master is the view of whatever drives and consumes it.
interface sub_bytes_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output busy
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  busy
  );
endinterface

// File: rtl/sub_bytes_seq.sv
// Iterative AES SubBytes: LANES forward S-boxes sweep the 16 state bytes, MSB byte first.
// Latency: out_valid rises 16/LANES edges after the accept edge; one state per 16/LANES+2 cycles.
// Backpressure: the result is held in DONE until out_ready; in_ready is high only in IDLE.
module sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic           clk,
  input  logic           rst,
  sub_bytes_seq_if.slave bus
);

  localparam int CHUNKS = 16 / LANES;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e         state_q, state_d;
  logic [127:0]   data_q, data_d;
  logic [127:0]   out_data_q, out_data_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_chunk;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[11'(2047 - 8 * int'(b)) -: 8];
  endfunction

  // Bit offset of byte (cnt*LANES + lane); byte 0 sits at [127:120].
  function automatic logic [6:0] byte_lsb(input logic [CW-1:0] c, input int lane);
    return 7'(8 * (15 - (int'(c) * LANES + lane)));
  endfunction

  assign last_chunk = (cnt_q == CW'(CHUNKS - 1));

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          data_d  = bus.in_data;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          data_d[byte_lsb(cnt_q, l) +: 8] = sbox(data_q[byte_lsb(cnt_q, l) +: 8]);
        end
        cnt_d = cnt_q + CW'(1);
        // The output register picks up the finished state as DONE is entered, never a partial one.
        if (last_chunk) begin
          out_data_d = data_d;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      out_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      out_data_q <= out_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == BUSY);
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: LANES=4 instance exercised in depth, LANES=1/2/8/16 run in lockstep
// for latency and data; expected values come from constants and an arithmetic GF(2^8) S-box model.
module tb_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;

  always #5 clk = ~clk;

  sub_bytes_seq_if if1 ();
  sub_bytes_seq_if if2 ();
  sub_bytes_seq_if if4 ();
  sub_bytes_seq_if if8 ();
  sub_bytes_seq_if if16 ();

  assign if1.in_valid  = in_valid;  assign if1.in_data  = in_data;  assign if1.out_ready  = out_ready;
  assign if2.in_valid  = in_valid;  assign if2.in_data  = in_data;  assign if2.out_ready  = out_ready;
  assign if4.in_valid  = in_valid;  assign if4.in_data  = in_data;  assign if4.out_ready  = out_ready;
  assign if8.in_valid  = in_valid;  assign if8.in_data  = in_data;  assign if8.out_ready  = out_ready;
  assign if16.in_valid = in_valid;  assign if16.in_data = in_data;  assign if16.out_ready = out_ready;

  sub_bytes_seq #(.LANES(1))  u_l1  (.clk(clk), .rst(rst), .bus(if1));
  sub_bytes_seq #(.LANES(2))  u_l2  (.clk(clk), .rst(rst), .bus(if2));
  sub_bytes_seq #(.LANES(4))  u_l4  (.clk(clk), .rst(rst), .bus(if4));
  sub_bytes_seq #(.LANES(8))  u_l8  (.clk(clk), .rst(rst), .bus(if8));
  sub_bytes_seq #(.LANES(16)) u_l16 (.clk(clk), .rst(rst), .bus(if16));

  logic         ov_a [5];
  logic [127:0] od_a [5];
  assign ov_a[0] = if1.out_valid;  assign od_a[0] = if1.out_data;
  assign ov_a[1] = if2.out_valid;  assign od_a[1] = if2.out_data;
  assign ov_a[2] = if4.out_valid;  assign od_a[2] = if4.out_data;
  assign ov_a[3] = if8.out_valid;  assign od_a[3] = if8.out_data;
  assign ov_a[4] = if16.out_valid; assign od_a[4] = if16.out_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sbox_ref [256];

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;
  vec_t vecs [5];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*(15-i) +: 8] = sbox_ref[s[8*(15-i) +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic send(input string name, input logic [127:0] d);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!if4.in_ready && n < 40) begin @(negedge clk); n++; end
    if (!if4.in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL %s: in_ready never rose within 40 cycles", name);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(input string name, output int cyc);
    cyc = 0;
    while (!if4.out_valid && cyc < 40) begin @(negedge clk); cyc++; end
    if (!if4.out_valid) begin
      n_tests++; n_fail++;
      $display("FAIL %s: out_valid never rose within 40 cycles", name);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int           cyc;
  logic [127:0] x, held;
  logic [127:0] ss [3];
  logic [127:0] se [3];
  int           idx, nout;
  int           ocyc [3];
  logic [127:0] odat [3];
  logic         adv, stale;
  int           seen [5];
  logic [127:0] got [5];
  int           lat_exp [5];

  initial begin
    vecs[0] = '{din: 128'h0, dout: {16{8'h63}}};
    vecs[1] = '{din: 128'h00112233445566778899aabbccddeeff,
                dout: 128'h638293c31bfc33f5c4eeacea4bc12816};
    vecs[2] = '{din: {16{8'h53}}, dout: {16{8'hed}}};
    vecs[3] = '{din: {16{8'h01}}, dout: {16{8'h7c}}};
    vecs[4] = '{din: {16{8'hff}}, dout: {16{8'h16}}};
    lat_exp = '{16, 8, 4, 2, 1};
    for (int i = 0; i < 256; i++) sbox_ref[i] = sbox_calc(8'(i));

    // Reset values while rst is held
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  128'(if4.in_ready),  128'd1);
    chk("rst_out_valid", 128'(if4.out_valid), 128'd0);
    chk("rst_busy",      128'(if4.busy),      128'd0);
    chk("rst_out_data",  if4.out_data,        128'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven known vectors, LANES=4
    for (int i = 0; i < 5; i++) begin
      send("vec_send", vecs[i].din);
      chk("vec_busy", 128'(if4.busy), 128'd1);
      wait_ov("vec_wait", cyc);
      chk("vec_latency", 128'(cyc), 128'd4);
      chk("vec_data", if4.out_data, vecs[i].dout);
      consume();
    end

    // Input changes after the accept edge must not leak into the result
    x = rnd128();
    send("stab_send", x);
    in_data = ~x;
    @(negedge clk);
    in_data = rnd128();
    wait_ov("stab_wait", cyc);
    chk("stab_data", if4.out_data, model(x));
    consume();

    // Back-pressure: hold DONE, offer all-FF meanwhile, then release
    x = rnd128();
    send("bp_send", x);
    wait_ov("bp_wait", cyc);
    chk("bp_first", if4.out_data, model(x));
    held     = if4.out_data;
    in_data  = {16{8'hff}};
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 128'(if4.out_valid), 128'd1);
      chk("bp_hold_data",  if4.out_data,        held);
      chk("bp_hold_ready", 128'(if4.in_ready),  128'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_ready_after", 128'(if4.in_ready), 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_ov("bp_wait2", cyc);
    chk("bp_ff_data", if4.out_data, {16{8'h16}});
    consume();

    // Streaming with in_valid and out_ready held high
    ss = '{{16{8'h53}}, {16{8'h01}}, {16{8'hff}}};
    se = '{{16{8'hed}}, {16{8'h7c}}, {16{8'h16}}};
    idx = 0; nout = 0;
    in_data = ss[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (if4.out_valid && nout < 3) begin
        ocyc[nout] = c; odat[nout] = if4.out_data; nout++;
      end
      adv = in_valid && if4.in_ready;
      @(negedge clk);
      if (adv) begin
        idx++;
        if (idx < 3) in_data = ss[idx];
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("stream_count", 128'(nout), 128'd3);
    if (nout == 3) begin
      for (int k = 0; k < 3; k++) chk("stream_data", odat[k], se[k]);
      chk("stream_gap01", 128'(ocyc[1] - ocyc[0]), 128'd6);
      chk("stream_gap12", 128'(ocyc[2] - ocyc[1]), 128'd6);
    end

    // Random states with random downstream stalls
    for (int t = 0; t < 30; t++) begin
      x = rnd128();
      send("rnd_send", x);
      wait_ov("rnd_wait", cyc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk("rnd_data", if4.out_data, model(x));
      consume();
    end

    // Asynchronous reset two cycles into BUSY
    send("mid_send", rnd128());
    repeat (2) @(negedge clk);
    chk("mid_busy_before", 128'(if4.busy), 128'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready",  128'(if4.in_ready),  128'd1);
    chk("mid_rst_out_valid", 128'(if4.out_valid), 128'd0);
    chk("mid_rst_busy",      128'(if4.busy),      128'd0);
    chk("mid_rst_out_data",  if4.out_data,        128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stale = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if4.out_valid || if4.busy) stale = 1'b1;
    end
    chk("mid_no_stale", 128'(stale), 128'd0);

    // All lane counts in lockstep: known vector first, then random states
    for (int t = 0; t < 5; t++) begin
      x = (t == 0) ? vecs[1].din : rnd128();
      in_data  = x;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int l = 0; l < 5; l++) begin seen[l] = -1; got[l] = '0; end
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        for (int l = 0; l < 5; l++) begin
          if (seen[l] < 0 && ov_a[l]) begin seen[l] = c; got[l] = od_a[l]; end
        end
      end
      for (int l = 0; l < 5; l++) begin
        if (t == 0) chk("lanes_latency", 128'(seen[l]), 128'(lat_exp[l]));
        chk("lanes_data", got[l], model(x));
      end
      chk("lanes_fullrange", (t == 0) ? got[0] : vecs[1].dout, vecs[1].dout);
      consume();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
